// File: rtl/reg_file_arb_if.sv
// Requester-side bus of the register-file arbiter: two requesters' operands,
// grant/completion strobes, read results and the scrub handshake.
interface reg_file_arb_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
);
    logic [1:0]         req;
    logic [1:0]         we;
    logic [2*AW-1:0]    aaddr;
    logic [2*AW-1:0]    baddr;
    logic [2*AW-1:0]    caddr;
    logic [2*WIDTH-1:0] wdata;
    logic               scrub_start;
    logic [1:0]         gnt;
    logic [1:0]         done;
    logic [WIDTH-1:0]   rd_A;
    logic [WIDTH-1:0]   rd_B;
    logic               scrub_busy;

    modport slave (
        input  req, we, aaddr, baddr, caddr, wdata, scrub_start,
        output gnt, done, rd_A, rd_B, scrub_busy
    );

    modport master (
        output req, we, aaddr, baddr, caddr, wdata, scrub_start,
        input  gnt, done, rd_A, rd_B, scrub_busy
    );
endinterface

// File: rtl/reg_file_arb.sv
// Two-requester round-robin arbiter in front of a 2-read/1-write register file,
// with a 16-cycle zeroing scrub that pre-empts pending requests.
module reg_file_arb #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             nClear,
    reg_file_arb_if.slave    bus,
    output logic [AW-1:0]    rf_Aaddr,
    output logic [AW-1:0]    rf_Baddr,
    output logic [AW-1:0]    rf_Caddr,
    output logic [WIDTH-1:0] rf_C,
    output logic             rf_load,
    input  logic [WIDTH-1:0] rf_A,
    input  logic [WIDTH-1:0] rf_B
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, SCRUB} state_e;

    state_e           state_q, state_d;
    logic             win_q, win_d;
    logic             last_q, last_d;
    logic [AW-1:0]    lat_caddr_q, lat_caddr_d;
    logic [WIDTH-1:0] lat_wdata_q, lat_wdata_d;
    logic             lat_we_q, lat_we_d;
    logic             pend_q, pend_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [WIDTH-1:0] rd_a_q, rd_a_d;
    logic [WIDTH-1:0] rd_b_q, rd_b_d;
    logic             busy_q, busy_d;
    logic [AW-1:0]    rf_aaddr_q, rf_aaddr_d;
    logic [AW-1:0]    rf_baddr_q, rf_baddr_d;
    logic [AW-1:0]    rf_caddr_q, rf_caddr_d;
    logic [WIDTH-1:0] rf_c_q, rf_c_d;
    logic             rf_load_q, rf_load_d;
    logic             pick;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        win_d       = win_q;
        last_d      = last_q;
        lat_caddr_d = lat_caddr_q;
        lat_wdata_d = lat_wdata_q;
        lat_we_d    = lat_we_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        done_d      = '0;
        busy_d      = 1'b0;
        rf_load_d   = 1'b0;
        rd_a_d      = rd_a_q;
        rd_b_d      = rd_b_q;
        rf_aaddr_d  = rf_aaddr_q;
        rf_baddr_d  = rf_baddr_q;
        rf_caddr_d  = rf_caddr_q;
        rf_c_d      = rf_c_q;

        // A lone request wins; a tie goes to whoever was not granted last.
        if (bus.req == 2'b10)      pick = 1'b1;
        else if (bus.req == 2'b01) pick = 1'b0;
        else                       pick = ~last_q;

        if (bus.scrub_start && state_q != SCRUB) pend_d = 1'b1;

        unique case (state_q)
            IDLE, WRITE: begin
                state_d = IDLE;
                if (pend_d) begin
                    state_d    = SCRUB;
                    cnt_d      = '0;
                    rf_caddr_d = '0;
                    rf_c_d     = '0;
                    rf_load_d  = 1'b1;
                    busy_d     = 1'b1;
                end else if (|bus.req) begin
                    state_d     = READ;
                    win_d       = pick;
                    last_d      = pick;
                    gnt_d[pick] = 1'b1;
                    rf_aaddr_d  = pick ? bus.aaddr[2*AW-1:AW] : bus.aaddr[AW-1:0];
                    rf_baddr_d  = pick ? bus.baddr[2*AW-1:AW] : bus.baddr[AW-1:0];
                    lat_caddr_d = pick ? bus.caddr[2*AW-1:AW] : bus.caddr[AW-1:0];
                    lat_wdata_d = pick ? bus.wdata[2*WIDTH-1:WIDTH] : bus.wdata[WIDTH-1:0];
                    lat_we_d    = bus.we[pick];
                end
            end
            READ: begin
                // Capture happens before the write cycle, so a same-address
                // write still returns the old contents.
                state_d      = WRITE;
                rd_a_d       = rf_A;
                rd_b_d       = rf_B;
                rf_caddr_d   = lat_caddr_q;
                rf_c_d       = lat_wdata_q;
                rf_load_d    = lat_we_q;
                done_d[win_q] = 1'b1;
            end
            SCRUB: begin
                rf_c_d = '0;
                if (cnt_q == 4'd15) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = cnt_q + 4'd1;
                    rf_caddr_d = AW'(cnt_q + 4'd1);
                    rf_load_d  = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            state_q     <= IDLE;
            win_q       <= 1'b0;
            last_q      <= 1'b1;
            lat_caddr_q <= '0;
            lat_wdata_q <= '0;
            lat_we_q    <= 1'b0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rd_a_q      <= '0;
            rd_b_q      <= '0;
            busy_q      <= 1'b0;
            rf_aaddr_q  <= '0;
            rf_baddr_q  <= '0;
            rf_caddr_q  <= '0;
            rf_c_q      <= '0;
            rf_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            last_q      <= last_d;
            lat_caddr_q <= lat_caddr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_we_q    <= lat_we_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rd_a_q      <= rd_a_d;
            rd_b_q      <= rd_b_d;
            busy_q      <= busy_d;
            rf_aaddr_q  <= rf_aaddr_d;
            rf_baddr_q  <= rf_baddr_d;
            rf_caddr_q  <= rf_caddr_d;
            rf_c_q      <= rf_c_d;
            rf_load_q   <= rf_load_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.rd_A       = rd_a_q;
    assign bus.rd_B       = rd_b_q;
    assign bus.scrub_busy = busy_q;
    assign rf_Aaddr       = rf_aaddr_q;
    assign rf_Baddr       = rf_baddr_q;
    assign rf_Caddr       = rf_caddr_q;
    assign rf_C           = rf_c_q;
    assign rf_load        = rf_load_q;

endmodule

// File: tb/tb_reg_file_arb.sv
// Bench for reg_file_arb: a behavioural register file, a vector table of
// single-requester operations, and directed tie, scrub and reset sequences.
module tb_reg_file_arb;

    typedef struct {
        logic [1:0]  done;
        logic [15:0] rd_a;
        logic [15:0] rd_b;
        logic [3:0]  caddr;
        logic [15:0] c;
        logic        load;
    } exp_t;

    typedef struct {
        int          r;
        logic        we;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  c;
        logic [15:0] d;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        nClear;
    logic [3:0]  rf_Aaddr, rf_Baddr, rf_Caddr;
    logic [15:0] rf_C, rf_A, rf_B;
    logic        rf_load;
    logic [15:0] rf_mem [16] = '{default: '0};
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        sb_q [$];
    exp_t        mon_e;
    vec_t        vecs [6];

    reg_file_arb_if #(.WIDTH(16), .AW(4)) bus ();

    reg_file_arb #(.WIDTH(16), .AW(4)) dut (
        .clk      (clk),
        .nClear   (nClear),
        .bus      (bus),
        .rf_Aaddr (rf_Aaddr),
        .rf_Baddr (rf_Baddr),
        .rf_Caddr (rf_Caddr),
        .rf_C     (rf_C),
        .rf_load  (rf_load),
        .rf_A     (rf_A),
        .rf_B     (rf_B)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rf_A = rf_mem[rf_Aaddr];
    assign rf_B = rf_mem[rf_Baddr];
    always @(posedge clk) if (rf_load) rf_mem[rf_Caddr] <= rf_C;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, got no event expected one", name);
    endtask

    // Completion monitor: every done strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (nClear && bus.done != 2'b00) begin
            if (sb_q.size() == 0) begin
                check("done_unexpected", bus.done, 2'b00);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_strobe", bus.done, mon_e.done);
                check("rd_A", bus.rd_A, mon_e.rd_a);
                check("rd_B", bus.rd_B, mon_e.rd_b);
                check("wr_rf_Caddr", rf_Caddr, mon_e.caddr);
                check("wr_rf_C", rf_C, mon_e.c);
                check("wr_rf_load", rf_load, mon_e.load);
                check("wr_gnt", bus.gnt, 2'b00);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, bus.gnt, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_rd_A"}, bus.rd_A, 0);
        check({tag, "_rd_B"}, bus.rd_B, 0);
        check({tag, "_busy"}, bus.scrub_busy, 0);
        check({tag, "_rf_addrs"}, {rf_Aaddr, rf_Baddr, rf_Caddr}, 0);
        check({tag, "_rf_C"}, rf_C, 0);
        check({tag, "_rf_load"}, rf_load, 0);
    endtask

    task automatic set_fields(input int r, input logic we, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] c, input logic [15:0] d);
        bus.we[r]          = we;
        bus.aaddr[4*r +: 4] = a;
        bus.baddr[4*r +: 4] = b;
        bus.caddr[4*r +: 4] = c;
        bus.wdata[16*r +: 16] = d;
    endtask

    task automatic push_exp(input int r, input logic we, input logic [3:0] c,
                            input logic [15:0] d, input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        e.done  = 2'b01 << r;
        e.rd_a  = ea;
        e.rd_b  = eb;
        e.caddr = c;
        e.c     = d;
        e.load  = we;
        sb_q.push_back(e);
    endtask

    task automatic wait_gnt(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.gnt == 2'b00 && lat < 40);
        if (bus.gnt == 2'b00) fail_timeout("gnt_wait");
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done == 2'b00 && n < 40);
        if (bus.done == 2'b00) fail_timeout("done_wait");
    endtask

    // One operation from requester r; operands are scrambled right after the
    // grant to show they were latched.
    task automatic do_op(input int r, input logic we, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [15:0] d,
                         input logic [15:0] ea, input logic [15:0] eb, input bit chk_lat);
        int lat;
        set_fields(r, we, a, b, c, d);
        bus.req[r] = 1'b1;
        push_exp(r, we, c, d, ea, eb);
        wait_gnt(lat);
        if (chk_lat) check("gnt_latency", lat, 1);
        check("gnt_onehot", bus.gnt, 2'b01 << r);
        check("read_rf_addrs", {rf_Aaddr, rf_Baddr}, {a, b});
        check("read_rf_load", rf_load, 1'b0);
        bus.req[r] = 1'b0;
        set_fields(r, ~we, ~a, ~b, ~c, ~d);
        wait_done();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int stamp;
        int prev;
        logic [1:0] tie_exp [4];

        vecs[0] = '{0, 1'b1, 4'd5,  4'd0,  4'd5,  16'hBEEF, 16'h0000, 16'h0000};
        vecs[1] = '{1, 1'b1, 4'd3,  4'd5,  4'd3,  16'h1234, 16'h0000, 16'hBEEF};
        vecs[2] = '{1, 1'b1, 4'd3,  4'd3,  4'd3,  16'hAAAA, 16'h1234, 16'h1234};
        vecs[3] = '{0, 1'b0, 4'd3,  4'd5,  4'd7,  16'h5555, 16'hAAAA, 16'hBEEF};
        vecs[4] = '{0, 1'b1, 4'd7,  4'd15, 4'd15, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[5] = '{1, 1'b0, 4'd15, 4'd5,  4'd0,  16'h0000, 16'hFFFF, 16'hBEEF};
        tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        nClear = 1'b0;
        bus.req = '0; bus.we = '0; bus.aaddr = '0; bus.baddr = '0;
        bus.caddr = '0; bus.wdata = '0; bus.scrub_start = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        nClear = 1'b1;

        // Table of single-requester operations, run back to back.
        for (int i = 0; i < 6; i++)
            do_op(vecs[i].r, vecs[i].we, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d,
                  vecs[i].exp_a, vecs[i].exp_b, 1'b1);
        @(negedge clk);
        check("idle_after_ops", {bus.gnt, bus.done, rf_load}, 5'b0);

        // Tie after reset: alternating grants, two cycles apart.
        @(negedge clk);
        nClear = 1'b0;
        #1;
        check("rst2_rd_A", bus.rd_A, 16'h0);
        check("rst2_rd_B", bus.rd_B, 16'h0);
        @(negedge clk);
        nClear = 1'b1;
        set_fields(0, 1'b0, 4'd5, 4'd3, 4'd1, 16'h0);
        set_fields(1, 1'b0, 4'd15, 4'd7, 4'd2, 16'h0);
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++)
            push_exp(k % 2, 1'b0, (k % 2) ? 4'd2 : 4'd1, 16'h0,
                     (k % 2) ? 16'hFFFF : 16'hBEEF, (k % 2) ? 16'h0000 : 16'hAAAA);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(lat);
            stamp = cyc;
            check("tie_gnt", bus.gnt, tie_exp[k]);
            if (k > 0) check("tie_spacing", stamp - prev, 2);
            prev = stamp;
        end
        bus.req = 2'b00;
        wait_done();

        // Scrub requested during READ; requests wait it out.
        set_fields(0, 1'b0, 4'd5, 4'd3, 4'd1, 16'h0);
        bus.req[0] = 1'b1;
        push_exp(0, 1'b0, 4'd1, 16'h0, 16'hBEEF, 16'hAAAA);
        wait_gnt(lat);
        check("scrub_pre_gnt", bus.gnt, 2'b01);
        bus.req[0] = 1'b0;
        bus.scrub_start = 1'b1;
        set_fields(1, 1'b1, 4'd5, 4'd5, 4'd9, 16'h5A5A);
        bus.req[1] = 1'b1;
        push_exp(1, 1'b1, 4'd9, 16'h5A5A, 16'h0, 16'h0);
        @(negedge clk);
        bus.scrub_start = 1'b0;
        check("scrub_pre_done", bus.done, 2'b01);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("scrub_cycle", {bus.scrub_busy, rf_load, rf_Caddr, rf_C, bus.gnt, bus.done},
                  {1'b1, 1'b1, 4'(k), 16'h0, 2'b00, 2'b00});
            if (k == 3) bus.scrub_start = 1'b1;
            if (k == 4) bus.scrub_start = 1'b0;
            if (k == 5) set_fields(0, 1'b1, 4'd1, 4'd1, 4'd1, 16'h1111);
            if (k == 5) bus.req[0] = 1'b1;
            if (k == 7) bus.req[0] = 1'b0;
        end
        @(negedge clk);
        check("scrub_end", {bus.scrub_busy, rf_load}, 2'b00);
        wait_gnt(lat);
        check("post_scrub_gnt", bus.gnt, 2'b10);
        bus.req[1] = 1'b0;
        wait_done();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_rescrub", {bus.scrub_busy, rf_load}, 2'b00);
        end
        do_op(0, 1'b0, 4'd9, 4'd9, 4'd0, 16'h0, 16'h5A5A, 16'h5A5A, 1'b1);

        // Reset at scrub address 7 abandons the scrub.
        bus.scrub_start = 1'b1;
        @(negedge clk);
        bus.scrub_start = 1'b0;
        lat = 0;
        while (!(bus.scrub_busy && rf_Caddr == 4'd7) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!(bus.scrub_busy && rf_Caddr == 4'd7)) fail_timeout("scrub_addr7");
        nClear = 1'b0;
        #1;
        check_all_zero("mid_scrub_reset");
        repeat (2) @(negedge clk);
        nClear = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_reset_quiet", {bus.scrub_busy, rf_load, bus.gnt}, 4'b0);
        end
        do_op(0, 1'b0, 4'd9, 4'd6, 4'd0, 16'h0, 16'h5A5A, 16'h0, 1'b1);

        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
